// File: rtl/aixh_mxc_upper_qtile_loader_if.sv
// Bundle of the row-word stream, load commands and column-side shift/capture
// signals between the tile loader and its neighbours.
interface aixh_mxc_upper_qtile_loader_if #(
  parameter int DWIDTH = 64
);
  logic              i_valid;
  logic [DWIDTH-1:0] i_data;
  logic              o_ready;
  logic              i_start;
  logic              i_flush;
  logic              o_senable;
  logic [DWIDTH-1:0] o_sdata;
  logic              o_csync;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_valid, i_data, i_start, i_flush,
    input  o_ready, o_senable, o_sdata, o_csync, o_busy, o_done, o_err
  );

  modport slave (
    input  i_valid, i_data, i_start, i_flush,
    output o_ready, o_senable, o_sdata, o_csync, o_busy, o_done, o_err
  );
endinterface

// File: rtl/aixh_mxc_upper_qtile_loader.sv
// Upper queue-tile column loader: buffers row words, shifts ROWS of them into
// the column on command, then strobes csync so all cells capture together.
module aixh_mxc_upper_qtile_loader #(
  parameter int DWIDTH     = 64,
  parameter int ROWS       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic aixh_core_clk,
  input  logic aixh_core_rstn,
  aixh_mxc_upper_qtile_loader_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SYNC = 2'd2
  } state_t;

  state_t            state;
  logic [RW-1:0]     row_cnt;
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic              push_p0;
  logic              pop_p0;
  logic              ready;
  logic              sen_p1;
  logic [DWIDTH-1:0] sdata_p1;
  logic              csync_p1;
  logic              done_p1;
  logic              err_p1;

  // Ready depends only on the registered count, so a full FIFO stays
  // closed even in a cycle where it is also being popped.
  assign ready   = (count != CW'(FIFO_DEPTH));
  assign push_p0 = bus.i_valid & ready & ~bus.i_flush;
  assign pop_p0  = (state == LOAD) & (count != '0) & ~bus.i_flush;

  always_ff @(posedge aixh_core_clk) begin
    if (push_p0) mem[wr_ptr] <= bus.i_data;
  end

  // Stage p0 -> p1: FIFO/FSM update and registered column outputs
  always_ff @(posedge aixh_core_clk or negedge aixh_core_rstn) begin
    if (!aixh_core_rstn) begin
      state    <= IDLE;
      row_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sen_p1   <= 1'b0;
      sdata_p1 <= '0;
      csync_p1 <= 1'b0;
      done_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else if (bus.i_flush) begin
      state    <= IDLE;
      row_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sen_p1   <= 1'b0;
      csync_p1 <= 1'b0;
      done_p1  <= 1'b0;
      err_p1   <= 1'b0;
    end else begin
      sen_p1   <= pop_p0;
      if (pop_p0) sdata_p1 <= mem[rd_ptr];
      csync_p1 <= (state == SYNC);
      done_p1  <= (state == SYNC);
      err_p1   <= bus.i_start & (state != IDLE);

      if (push_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_p0, pop_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (bus.i_start) begin
            state   <= LOAD;
            row_cnt <= '0;
          end
        end
        LOAD: begin
          if (pop_p0) begin
            row_cnt <= row_cnt + 1'b1;
            if (row_cnt == RW'(ROWS - 1)) state <= SYNC;
          end
        end
        SYNC:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_busy    = (state != IDLE);
  assign bus.o_senable = sen_p1;
  assign bus.o_sdata   = sdata_p1;
  assign bus.o_csync   = csync_p1;
  assign bus.o_done    = done_p1;
  assign bus.o_err     = err_p1;
endmodule

// File: tb/tb_aixh_mxc_upper_qtile_loader.sv
// Bench for the upper queue-tile loader: directed scenarios plus random traffic
// against a queue-based model of the loader's documented behaviour.
module tb_aixh_mxc_upper_qtile_loader;
  localparam int DW    = 16;
  localparam int NROWS = 4;
  localparam int DEPTH = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  aixh_mxc_upper_qtile_loader_if #(.DWIDTH(DW)) bus ();

  aixh_mxc_upper_qtile_loader #(
    .DWIDTH(DW), .ROWS(NROWS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .aixh_core_clk (clk),
    .aixh_core_rstn(rstn),
    .bus           (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: word queue plus the load's progress in words shifted.
  logic [DW-1:0] q[$];
  bit            m_load;
  bit            m_sync;
  int            m_rows;
  bit            e_sen, e_csync, e_done, e_err;
  logic [DW-1:0] e_sdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_load = 0; m_sync = 0; m_rows = 0;
    e_sen = 0; e_csync = 0; e_done = 0; e_err = 0; e_sdata = '0;
  endtask

  task automatic check_all();
    check("ready",   bus.o_ready,   q.size() != DEPTH);
    check("busy",    bus.o_busy,    m_load | m_sync);
    check("senable", bus.o_senable, e_sen);
    check("sdata",   bus.o_sdata,   e_sdata);
    check("csync",   bus.o_csync,   e_csync);
    check("done",    bus.o_done,    e_done);
    check("err",     bus.o_err,     e_err);
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit s, input bit f);
    bit can_push, can_pop, was_idle;
    bus.i_valid = v; bus.i_data = d; bus.i_start = s; bus.i_flush = f;
    @(posedge clk);
    can_push = (q.size() < DEPTH);
    can_pop  = m_load && (q.size() > 0);
    was_idle = !m_load && !m_sync;
    if (f) begin
      q.delete();
      m_load = 0; m_sync = 0; m_rows = 0;
      e_sen = 0; e_csync = 0; e_done = 0; e_err = 0;
    end else begin
      e_err   = s && !was_idle;
      e_csync = m_sync;
      e_done  = m_sync;
      e_sen   = 0;
      if (m_sync) m_sync = 0;
      else if (was_idle && s) begin
        m_load = 1; m_rows = 0;
      end else if (can_pop) begin
        e_sen   = 1;
        e_sdata = q.pop_front();
        m_rows++;
        if (m_rows == NROWS) begin
          m_load = 0; m_sync = 1;
        end
      end
      if (v && can_push) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  int last_sen;
  int sen_seen;

  initial begin
    bus.i_valid = 0; bus.i_data = '0; bus.i_start = 0; bus.i_flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_senable", bus.o_senable, 0);
    check("rst_sdata",   bus.o_sdata,   0);
    check("rst_csync",   bus.o_csync,   0);
    check("rst_done",    bus.o_done,    0);
    check("rst_err",     bus.o_err,     0);
    check("rst_busy",    bus.o_busy,    0);
    @(negedge clk) rstn = 1'b1;
    #1 check("rst_ready", bus.o_ready, 1);

    // Pre-filled load with explicit timing against the start cycle
    for (int i = 0; i < 4; i++) step(1, DW'(16'hA0 + i), 0, 0);
    for (int n = 0; n < 7; n++) begin
      step(0, '0, n == 0, 0);
      check("pf_sen", bus.o_senable, (n >= 1 && n <= 4));
      if (n >= 1 && n <= 4) check("pf_data", bus.o_sdata, 16'hA0 + n - 1);
      check("pf_csync", bus.o_csync, n == 5);
      check("pf_done",  bus.o_done,  n == 5);
      check("pf_busy",  bus.o_busy,  n <= 4);
    end

    // Starved load: one word every third cycle
    sen_seen = 0; last_sen = -10;
    for (int n = 0; n < 16; n++) begin
      step((n % 3) == 1 && n < 12, DW'(16'hB0 + n), n == 0, 0);
      if (bus.o_csync) check("starve_csync_gap", n - last_sen, 1);
      if (bus.o_senable) begin sen_seen++; last_sen = n; end
    end
    check("starve_pulses", sen_seen, 4);

    // Fill past capacity while idle, then two back-to-back loads across the wrap
    for (int i = 0; i < 6; i++) step(1, DW'(16'hC0 + i), 0, 0);
    for (int n = 0; n < 6; n++) step(1, DW'(16'hD0 + n), n == 0, 0);
    for (int n = 0; n < 8; n++) step(n < 3, DW'(16'hE0 + n), n == 0, 0);

    // Rejected start during LOAD
    for (int i = 0; i < 4; i++) step(1, DW'(16'h10 + i), 0, 0);
    for (int n = 0; n < 8; n++) step(0, '0, n == 0 || n == 2, 0);

    // Flush mid-load, then a fresh load of post-flush data
    for (int i = 0; i < 4; i++) step(1, DW'(16'h20 + i), 0, 0);
    for (int n = 0; n < 3; n++) step(0, '0, n == 0, 0);
    step(1, 16'hEEEE, 1, 1);
    check("flush_busy",  bus.o_busy,  0);
    check("flush_ready", bus.o_ready, 1);
    for (int n = 0; n < 4; n++) step(0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, DW'(16'h30 + i), 0, 0);
    for (int n = 0; n < 7; n++) step(0, '0, n == 0, 0);

    // Asynchronous reset between edges in the middle of a load
    for (int i = 0; i < 4; i++) step(1, DW'(16'h40 + i), 0, 0);
    for (int n = 0; n < 3; n++) step(0, '0, n == 0, 0);
    #2 rstn = 1'b0;
    #1;
    check("arst_senable", bus.o_senable, 0);
    check("arst_sdata",   bus.o_sdata,   0);
    check("arst_csync",   bus.o_csync,   0);
    check("arst_done",    bus.o_done,    0);
    check("arst_err",     bus.o_err,     0);
    check("arst_busy",    bus.o_busy,    0);
    model_reset();
    @(negedge clk) rstn = 1'b1;
    #1 check("arst_ready", bus.o_ready, 1);
    for (int n = 0; n < 6; n++) step(0, '0, n == 0, 0);
    step(0, '0, 0, 1);

    // Random traffic
    for (int n = 0; n < 600; n++)
      step($urandom_range(0, 1) == 1, DW'($urandom),
           $urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aixh_mxc_upper_qtile_loader.md
# aixh_mxc_upper_qtile_loader

Upstream sequencer for an MxConv upper queue-tile column. It buffers a stream of row words in a small FIFO and, on command, shifts exactly `ROWS` words into the column's vertical data interface, one word per cycle. It then issues a single-cycle horizontal `csync` so every cell in the column latches its word together. It runs entirely in the core 1x clock domain, and its outputs drive the column's `senable`, `sdata` and `csync` inputs directly.

## Interface
Parameters:
- `DWIDTH`, 64: width of one row word; equals the column cell data width.
- `ROWS`, 8: number of cells in the column, i.e. words per tile load; must be ≥ 1.
- `FIFO_DEPTH`, 4: input buffer entries; must be a power of two, ≥ 2.

Ports:
- `aixh_core_clk` (in, 1): core clock; the only clock.
- `aixh_core_rstn` (in, 1): asynchronous active-low reset.
- `i_valid` (in, 1): input word valid.
- `i_data` (in, DWIDTH): input row word.
- `o_ready` (out, 1): FIFO can accept a word this cycle.
- `i_start` (in, 1): single-cycle pulse; begin one tile load.
- `i_flush` (in, 1): empty the FIFO and abort any load.
- `o_senable` (out, 1): shift enable to the column.
- `o_sdata` (out, DWIDTH): shift data to the column.
- `o_csync` (out, 1): capture strobe to the column.
- `o_busy` (out, 1): a load is in progress.
- `o_done` (out, 1): single-cycle pulse when the tile load completes.
- `o_err` (out, 1): single-cycle pulse when `i_start` is rejected.

## Operation
- **FIFO.**
  - Push when `i_valid & o_ready`.
  - `o_ready = (count != FIFO_DEPTH)`, decoded from the registered count and independent of pop in the same cycle.
  - There is no bypass: a word pushed in cycle c can be popped no earlier than c+1.
  - Pointers wrap modulo `FIFO_DEPTH`. The count has `$clog2(FIFO_DEPTH)+1` bits.
  - The FIFO accepts words in every state, including while IDLE.
- **State machine** (IDLE, LOAD, SYNC):
  - IDLE: `i_start` moves to LOAD and clears the row counter.
  - LOAD: each cycle with the FIFO non-empty, pop one word and increment the row counter; an empty FIFO stalls without error. The pop that brings the counter to `ROWS` moves the FSM to SYNC.
  - SYNC: lasts one cycle, then returns to IDLE.
- **Row counter.** Width is `$clog2(ROWS+1)`; it never exceeds `ROWS`.
- **Registered outputs.**
  - A pop in cycle c gives `o_senable=1` and `o_sdata`=popped word in cycle c+1.
  - `o_senable=0` otherwise; `o_sdata` holds its last value when not enabled.
  - While in SYNC at cycle c, `o_csync=1` and `o_done=1` in cycle c+1.
  - `o_busy` is the decode `state != IDLE`.
- **Rejected start.** `i_start` in LOAD or SYNC is ignored; `o_err` pulses the next cycle and the load in progress is unaffected.
- **Flush.**
  - `i_flush` has priority over everything. It empties the FIFO, forces IDLE and zeroes the row counter.
  - In the cycle after the flush, `o_senable`, `o_csync` and `o_done` are 0. A pop registered in the same cycle as the flush is suppressed.
  - A push in the same cycle as `i_flush` is dropped.
  - No `csync` is issued for an aborted load.
- **Flush with start.** `i_start` together with `i_flush` is ignored, with no error.
- **Reset values.**
  - State is IDLE; FIFO and row counter are empty/zero.
  - `o_senable`, `o_csync`, `o_done`, `o_err` = 0; `o_sdata` = 0; `o_busy` = 0.
  - `o_ready` = 1 once reset is released.
  - Reset asserted mid-load discards the load. Outputs go to reset values asynchronously.

## Timing
- Start to first shift, FIFO pre-filled: `i_start` at t, LOAD at t+1 (first pop), first `o_senable` at t+2.
- With `ROWS` words available, pops occur t+1…t+ROWS, and `o_senable` is high t+2…t+ROWS+1 contiguously.
- SYNC at t+ROWS+1; `o_csync`/`o_done` high at t+ROWS+2, which is one cycle after the last `o_senable`. The FSM is in IDLE at t+ROWS+2.
- Earliest next accepted `i_start` is t+ROWS+2, giving a back-to-back period of `ROWS+2` cycles.
- A stall inserts gaps in `o_senable`. `o_csync` always follows the `ROWS`-th `o_senable` by exactly one cycle.
- Throughput: one push and one pop per cycle sustained. A full FIFO with a simultaneous pop still deasserts `o_ready` for that cycle.

## Test plan
Settings: ROWS=4, DWIDTH=16, FIFO_DEPTH=4.
- **Pre-filled load:** push 0xA0..0xA3, pulse `i_start` at t → `o_senable` at t+2..t+5 carrying 0xA0..0xA3 in order; `o_csync`=`o_done`=1 at t+6 only; `o_busy` high t+1..t+5.
- **Starved load:** `i_start` with FIFO empty, push one word every 3 cycles → 4 isolated `o_senable` pulses with data in order; `o_csync` exactly one cycle after the 4th; no `o_err`.
- **Full/wrap:** push 6 words while IDLE → `o_ready` drops after the 4th, and words 5–6 are held off. Two back-to-back loads with continued pushes → 8 words out in push order across the pointer wrap; `o_csync` at t+6 and t'+6.
- **Rejected start:** `i_start` during LOAD → `o_err` pulse the next cycle; the load completes unchanged with a single `o_csync`.
- **Flush mid-load:** `i_flush` after 2 shifts → no further `o_senable`, no `o_csync`/`o_done`; `o_busy`=0 and `o_ready`=1 the next cycle. A fresh load afterwards uses only post-flush data.
- **Async reset mid-load:** assert `aixh_core_rstn`=0 between clock edges during LOAD → all outputs are 0 immediately (`o_ready`=1 after release); the FIFO is empty after release.
